// File: rtl/watchdog_timer.sv
// Programmable watchdog: counts (optionally prescaled) tick strobes against a latched
// timeout, with early warning, kick service, sticky expiry flag and auto-reload.
module watchdog_timer #(
    parameter int CNT_W    = 10,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             tick,
    input  logic             kick,
    input  logic [CNT_W-1:0] timeout_val,
    input  logic [CNT_W-1:0] warn_val,
    input  logic             auto_reload,
    input  logic             clear_flag,
    output logic [CNT_W-1:0] count_val,
    output logic             warn,
    output logic             timeout_pulse,
    output logic             expired_flag,
    output logic             running
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        WARN    = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;
    logic [CNT_W-1:0] count_inc_s;
    logic [7:0]       presc_r;
    logic [7:0]       presc_s;
    logic [CNT_W-1:0] timeout_lat_r;
    logic [CNT_W-1:0] timeout_lat_s;
    logic [CNT_W-1:0] warn_lat_r;
    logic [CNT_W-1:0] warn_lat_s;
    logic             latch_s;
    logic             expire_s;
    logic             warn_hit_s;
    logic             at_term_s;
    logic             warn_r;
    logic             warn_s;
    logic             running_r;
    logic             running_s;
    logic             pulse_r;
    logic             pulse_s;
    logic             flag_r;
    logic             flag_s;

    assign count_inc_s = count_r + CNT_W'(1);
    assign at_term_s   = (count_r >= timeout_lat_r);
    assign warn_hit_s  = (warn_lat_r != '0) && (count_inc_s >= warn_lat_r);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and datapath decisions; kick takes priority over an increment
    always_comb begin
        state_s  = state_r;
        count_s  = count_r;
        presc_s  = presc_r;
        latch_s  = 1'b0;
        expire_s = 1'b0;
        if (!enable) begin
            state_s = IDLE;
            count_s = '0;
            presc_s = 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = RUN;
                    count_s = '0;
                    presc_s = 8'd0;
                    latch_s = 1'b1;
                end
                RUN, WARN: begin
                    if (kick) begin
                        state_s = RUN;
                        count_s = '0;
                        presc_s = 8'd0;
                        latch_s = 1'b1;
                    end else if (tick) begin
                        if (presc_r == PRESC_LAST) begin
                            presc_s = 8'd0;
                            if (!at_term_s) begin
                                count_s = count_inc_s;
                                state_s = warn_hit_s ? WARN : RUN;
                            end else begin
                                expire_s = 1'b1;
                                count_s  = '0;
                                state_s  = auto_reload ? RUN : EXPIRED;
                                latch_s  = auto_reload;
                            end
                        end else begin
                            presc_s = presc_r + 8'd1;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                EXPIRED: begin
                    count_s = '0;
                    presc_s = 8'd0;
                    if (kick) begin
                        state_s = RUN;
                        latch_s = 1'b1;
                    end else begin
                        state_s = EXPIRED;
                    end
                end
                default: begin
                    state_s = IDLE;
                    count_s = '0;
                    presc_s = 8'd0;
                end
            endcase
        end
    end

    // Next values of the registered outputs and latched thresholds
    always_comb begin
        warn_s        = (state_s == WARN);
        running_s     = (state_s == RUN) || (state_s == WARN);
        pulse_s       = expire_s;
        timeout_lat_s = latch_s ? timeout_val : timeout_lat_r;
        warn_lat_s    = latch_s ? warn_val : warn_lat_r;
        if (expire_s) begin
            flag_s = 1'b1;
        end else if (clear_flag) begin
            flag_s = 1'b0;
        end else begin
            flag_s = flag_r;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r       <= '0;
            presc_r       <= 8'd0;
            timeout_lat_r <= '0;
            warn_lat_r    <= '0;
            warn_r        <= 1'b0;
            running_r     <= 1'b0;
            pulse_r       <= 1'b0;
            flag_r        <= 1'b0;
        end else begin
            count_r       <= count_s;
            presc_r       <= presc_s;
            timeout_lat_r <= timeout_lat_s;
            warn_lat_r    <= warn_lat_s;
            warn_r        <= warn_s;
            running_r     <= running_s;
            pulse_r       <= pulse_s;
            flag_r        <= flag_s;
        end
    end

    assign count_val     = count_r;
    assign warn          = warn_r;
    assign timeout_pulse = pulse_r;
    assign expired_flag  = flag_r;
    assign running       = running_r;

endmodule

// File: doc/watchdog_timer.md
Name: watchdog_timer

Overview:
- Parametrised successor to the fixed 1000-count watchdog.
- Counts qualified tick strobes, optionally divided by a prescaler, against a run-time programmable timeout.
- Provides early warning, service (kick), sticky expiry flag, and one-shot or auto-reload modes.
- Sits between the game timing strobe (e.g. 1 ms tick) and the game-control FSM, which kicks it on player input and reacts to warn/expiry.

Parameters:
- CNT_W, 10, width of timeout counter, timeout_val, warn_val and count_val.
- PRESCALE, 1, ticks per counter increment (1 = no prescale); legal range 1..255.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- enable  input  1  watchdog enable; 0 forces IDLE.
- tick  input  1  count strobe, one clk wide per event.
- kick  input  1  service strobe; restarts the timeout.
- timeout_val  input  CNT_W  terminal count; expiry occurs on increment (timeout_val+1) after load.
- warn_val  input  CNT_W  warning threshold; 0 disables warning.
- auto_reload  input  1  1: restart after expiry; 0: stop in EXPIRED.
- clear_flag  input  1  clears expired_flag.
- count_val  output  CNT_W  current counter value.
- warn  output  1  high while in WARN state.
- timeout_pulse  output  1  one-clk pulse on expiry.
- expired_flag  output  1  sticky expiry indicator.
- running  output  1  high in RUN or WARN.

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; counter, prescaler, latched values and all outputs 0. Applies from any state, mid-operation included.
- States: IDLE, RUN, WARN, EXPIRED. All outputs registered.
- Latching: timeout_val and warn_val are latched on IDLE->RUN, on every accepted kick, and on auto-reload. Changes at other times have no effect.
- Increment event: tick=1 while the prescaler equals PRESCALE-1; the prescaler then wraps to 0, otherwise it increments on tick. Prescaler clears on kick, on entering RUN, and on expiry.
- enable=0 (any non-reset state): next state IDLE; counter, prescaler, warn, running, timeout_pulse go to 0. expired_flag is retained.
- IDLE:
  - enable=1 -> RUN next cycle; counter 0; values latched.
  - kick and tick are ignored.
- RUN / WARN, priority kick > increment:
  - Kick: counter 0, re-latch, state RUN, warn 0. No expiry occurs even if an increment coincides at terminal count.
  - Increment with counter < timeout_lat: counter+1. If warn_lat != 0 and the new value >= warn_lat, state WARN; warn rises the same cycle count_val shows the new value.
  - Increment with counter >= timeout_lat: expiry. timeout_pulse=1 for exactly one cycle, expired_flag=1, counter 0, warn 0.
    - auto_reload=1: state RUN, re-latch.
    - auto_reload=0: state EXPIRED.
  - timeout_val=0: every increment expires.
  - warn_val > timeout_val: warn never asserts.
- EXPIRED:
  - running=0, counter 0; ticks ignored.
  - kick -> RUN, counter 0, re-latch.
  - enable=0 -> IDLE.
- expired_flag:
  - Set on expiry; cleared by clear_flag or reset.
  - Expiry and clear_flag in the same cycle: set wins.
- Counter arithmetic: unsigned CNT_W bits. The counter never exceeds timeout_lat, so no wrap-around is possible.
- Latency:
  - kick / enable effects visible the cycle after the sampling edge.
  - timeout_pulse asserts the cycle after the terminal increment is sampled.

Test Plan:
- Defaults, timeout_val=999, warn_val=0, auto_reload=1, enable=1, tick every cycle -> timeout_pulse on the cycle after the 1000th tick; pulses repeat every 1000 ticks; count_val 999->0; expired_flag=1.
- timeout_val=9, warn_val=7, auto_reload=0 -> warn rises as count_val=7; pulse after 10th tick; state EXPIRED, running=0, further ticks leave count_val=0; kick -> running=1, count_val=0.
- timeout_val=9, kick coincident with 10th tick -> no pulse, count_val=0, expired_flag unchanged; kick at count 5 then 10 more ticks -> pulse.
- PRESCALE=4, timeout_val=2 -> count_val increments every 4th tick; pulse after 12th tick; kick mid-prescale resets prescale phase.
- clear_flag asserted same cycle as expiry -> expired_flag=1; clear_flag next cycle -> 0. enable dropped in WARN -> next cycle warn=0, running=0, expired_flag held.
- rst=0 while count_val=500 in WARN -> next cycle all outputs 0, state IDLE; rst=1 with enable=1 -> RUN, counting from 0.
